mem_port_a_arbiter: RTL and testbench

- Shares main memory's single word-wide read/write port (port A) between two requesters:
  - the MIC-1 datapath (MAR/MDR rd/wr), requester 0 (cpu);
  - a host program-loader/debug interface, requester 1 (host).
- Serialises accesses, round-robin fairness between the two, one-cycle response pulse per accepted access.
- Blocks out-of-range addresses before they reach the memory.
- Port B (byte fetch) is not touched by this block.

---
 rtl/mem_arb_pkg.sv | 25 ++
 rtl/rr_arbiter2.sv | 22 ++
 rtl/mem_port_a_arbiter.sv | 176 +++++++++++++++++
 tb/tb_mem_port_a_arbiter.sv | 336 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the main-memory port A arbiter.
package mem_arb_pkg;

    localparam int unsigned ADDR_W          = 32;
    localparam int unsigned DATA_W          = 32;
    localparam int unsigned DEF_MEMORY_SIZE = 'h0083;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    typedef enum logic {
        REQ_CPU  = 1'b0,
        REQ_HOST = 1'b1
    } req_id_t;

    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } mem_cmd_t;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin pick: a tie goes to the requester that was not served last.
module rr_arbiter2
    import mem_arb_pkg::*;
(
    input  logic    cpu_req,
    input  logic    host_req,
    input  req_id_t rr_last,
    output req_id_t winner_c,
    output logic    valid_c
);

    always_comb begin
        valid_c  = cpu_req | host_req;
        winner_c = REQ_CPU;
        if (cpu_req && host_req) begin
            winner_c = (rr_last == REQ_CPU) ? REQ_HOST : REQ_CPU;
        end else if (host_req) begin
            winner_c = REQ_HOST;
        end
    end

endmodule

// File: rtl/mem_port_a_arbiter.sv
// Serialises cpu and host word accesses onto memory port A with range blocking
// and a one-cycle grant / one-cycle response handshake.
module mem_port_a_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned MEMORY_SIZE = DEF_MEMORY_SIZE
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_gnt,
    output logic              cpu_rsp_valid,
    output logic              cpu_rsp_err,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              host_req,
    input  logic              host_we,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [DATA_W-1:0] host_wdata,
    output logic              host_gnt,
    output logic              host_rsp_valid,
    output logic              host_rsp_err,
    output logic [DATA_W-1:0] host_rdata,
    output logic              mem_wen,
    output logic              mem_ren,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    state_t  state, state_nxt;
    req_id_t rr_last, rr_nxt;
    req_id_t id_q, id_nxt;
    logic    we_q, we_nxt;
    logic    err_q, err_nxt;

    req_id_t  arb_winner;
    logic     arb_valid;
    mem_cmd_t sel_cmd;
    logic     sel_err;

    logic              cpu_gnt_nxt, host_gnt_nxt;
    logic              cpu_rsp_valid_nxt, host_rsp_valid_nxt;
    logic              cpu_rsp_err_nxt, host_rsp_err_nxt;
    logic [DATA_W-1:0] cpu_rdata_nxt, host_rdata_nxt, rsp_data;
    logic              mem_wen_nxt, mem_ren_nxt;
    logic [ADDR_W-1:0] mem_addr_nxt;
    logic [DATA_W-1:0] mem_wdata_nxt;

    rr_arbiter2 u_rr (
        .cpu_req  (cpu_req),
        .host_req (host_req),
        .rr_last  (rr_last),
        .winner_c (arb_winner),
        .valid_c  (arb_valid)
    );

    // The winner's command goes straight into the memory-side output registers.
    always_comb begin
        if (arb_winner == REQ_HOST) begin
            sel_cmd = {host_we, host_addr, host_wdata};
        end else begin
            sel_cmd = {cpu_we, cpu_addr, cpu_wdata};
        end
        sel_err = (sel_cmd.addr >= ADDR_W'(MEMORY_SIZE));
    end

    always_comb begin
        state_nxt          = state;
        rr_nxt             = rr_last;
        id_nxt             = id_q;
        we_nxt             = we_q;
        err_nxt            = err_q;
        cpu_gnt_nxt        = 1'b0;
        host_gnt_nxt       = 1'b0;
        cpu_rsp_valid_nxt  = 1'b0;
        host_rsp_valid_nxt = 1'b0;
        cpu_rsp_err_nxt    = 1'b0;
        host_rsp_err_nxt   = 1'b0;
        cpu_rdata_nxt      = '0;
        host_rdata_nxt     = '0;
        mem_wen_nxt        = 1'b0;
        mem_ren_nxt        = 1'b0;
        mem_addr_nxt       = '0;
        mem_wdata_nxt      = '0;
        rsp_data           = (!err_q && !we_q) ? mem_rdata : '0;

        case (state)
            IDLE, RESP: begin
                if (arb_valid) begin
                    state_nxt = ACCESS;
                    rr_nxt    = arb_winner;
                    id_nxt    = arb_winner;
                    we_nxt    = sel_cmd.we;
                    err_nxt   = sel_err;
                    if (arb_winner == REQ_HOST) begin
                        host_gnt_nxt = 1'b1;
                    end else begin
                        cpu_gnt_nxt = 1'b1;
                    end
                    if (!sel_err) begin
                        mem_wen_nxt   = sel_cmd.we;
                        mem_ren_nxt   = !sel_cmd.we;
                        mem_addr_nxt  = sel_cmd.addr;
                        mem_wdata_nxt = sel_cmd.wdata;
                    end
                end else begin
                    state_nxt = IDLE;
                end
            end
            ACCESS: begin
                state_nxt = RESP;
                if (id_q == REQ_HOST) begin
                    host_rsp_valid_nxt = 1'b1;
                    host_rsp_err_nxt   = err_q;
                    host_rdata_nxt     = rsp_data;
                end else begin
                    cpu_rsp_valid_nxt = 1'b1;
                    cpu_rsp_err_nxt   = err_q;
                    cpu_rdata_nxt     = rsp_data;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            rr_last <= REQ_HOST;
            id_q    <= REQ_CPU;
            we_q    <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state   <= state_nxt;
            rr_last <= rr_nxt;
            id_q    <= id_nxt;
            we_q    <= we_nxt;
            err_q   <= err_nxt;
        end
    end

    // Output registers; every handshake and memory signal is a registered pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cpu_gnt        <= 1'b0;
            host_gnt       <= 1'b0;
            cpu_rsp_valid  <= 1'b0;
            host_rsp_valid <= 1'b0;
            cpu_rsp_err    <= 1'b0;
            host_rsp_err   <= 1'b0;
            cpu_rdata      <= '0;
            host_rdata     <= '0;
            mem_wen        <= 1'b0;
            mem_ren        <= 1'b0;
            mem_addr       <= '0;
            mem_wdata      <= '0;
        end else begin
            cpu_gnt        <= cpu_gnt_nxt;
            host_gnt       <= host_gnt_nxt;
            cpu_rsp_valid  <= cpu_rsp_valid_nxt;
            host_rsp_valid <= host_rsp_valid_nxt;
            cpu_rsp_err    <= cpu_rsp_err_nxt;
            host_rsp_err   <= host_rsp_err_nxt;
            cpu_rdata      <= cpu_rdata_nxt;
            host_rdata     <= host_rdata_nxt;
            mem_wen        <= mem_wen_nxt;
            mem_ren        <= mem_ren_nxt;
            mem_addr       <= mem_addr_nxt;
            mem_wdata      <= mem_wdata_nxt;
        end
    end

endmodule

// File: tb/tb_mem_port_a_arbiter.sv
// Bench for mem_port_a_arbiter: directed scenarios plus a randomized run against
// a transaction-level model of the arbitration and memory contents.
module tb_mem_port_a_arbiter;

    localparam int unsigned MSIZE = 'h83;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cpu_req = 1'b0, cpu_we = 1'b0;
    logic [31:0] cpu_addr = '0, cpu_wdata = '0;
    logic        cpu_gnt, cpu_rsp_valid, cpu_rsp_err;
    logic [31:0] cpu_rdata;
    logic        host_req = 1'b0, host_we = 1'b0;
    logic [31:0] host_addr = '0, host_wdata = '0;
    logic        host_gnt, host_rsp_valid, host_rsp_err;
    logic [31:0] host_rdata;
    logic        mem_wen, mem_ren;
    logic [31:0] mem_addr, mem_wdata;
    logic [31:0] mem_rdata = '0;

    logic [31:0] mem [0:MSIZE-1];
    logic [31:0] ref_mem [0:MSIZE-1];
    int n_checks = 0;
    int n_fail = 0;

    wire [135:0] all_out = {cpu_gnt, cpu_rsp_valid, cpu_rsp_err, cpu_rdata,
                            host_gnt, host_rsp_valid, host_rsp_err, host_rdata,
                            mem_wen, mem_ren, mem_addr, mem_wdata};

    mem_port_a_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_gnt(cpu_gnt), .cpu_rsp_valid(cpu_rsp_valid), .cpu_rsp_err(cpu_rsp_err),
        .cpu_rdata(cpu_rdata),
        .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
        .host_gnt(host_gnt), .host_rsp_valid(host_rsp_valid), .host_rsp_err(host_rsp_err),
        .host_rdata(host_rdata),
        .mem_wen(mem_wen), .mem_ren(mem_ren), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // Main memory: registers on the falling edge.
    always @(negedge clk) begin
        if (mem_wen && mem_addr < MSIZE) mem[mem_addr] <= mem_wdata;
        if (mem_ren && mem_addr < MSIZE) mem_rdata <= mem[mem_addr];
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        tick();
        tick();
        n_checks++;
        if (all_out !== '0) begin n_fail++; $display("FAIL reset_outputs: got %h expected 0", all_out); end
        rst_n = 1'b1;
        tick();
        n_checks++;
        if (all_out !== '0) begin n_fail++; $display("FAIL idle_outputs: got %h expected 0", all_out); end
    endtask

    task automatic test_cpu_read();
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'd5;
        tick();
        n_checks++;
        if ({cpu_gnt, host_gnt, mem_ren, mem_wen} !== 4'b1010) begin
            n_fail++; $display("FAIL cpu_read_gnt: got %b expected 1010", {cpu_gnt, host_gnt, mem_ren, mem_wen});
        end
        n_checks++;
        if (mem_addr !== 32'd5) begin n_fail++; $display("FAIL cpu_read_addr: got %h expected 5", mem_addr); end
        cpu_req = 1'b0;
        tick();
        n_checks++;
        if ({cpu_rsp_valid, cpu_rsp_err, cpu_gnt, mem_ren} !== 4'b1000) begin
            n_fail++; $display("FAIL cpu_read_rsp: got %b expected 1000", {cpu_rsp_valid, cpu_rsp_err, cpu_gnt, mem_ren});
        end
        n_checks++;
        if (cpu_rdata !== 32'hDEADBEEF) begin n_fail++; $display("FAIL cpu_read_data: got %h expected deadbeef", cpu_rdata); end
        tick();
        n_checks++;
        if ({cpu_rsp_valid, cpu_rdata} !== 33'd0) begin
            n_fail++; $display("FAIL cpu_read_after: got %h expected 0", {cpu_rsp_valid, cpu_rdata});
        end
    endtask

    task automatic test_host_write_cpu_read();
        host_req = 1'b1; host_we = 1'b1; host_addr = 32'd3; host_wdata = 32'h12345678;
        tick();
        n_checks++;
        if ({host_gnt, cpu_gnt, mem_wen, mem_ren, mem_addr, mem_wdata} !== {4'b1010, 32'd3, 32'h12345678}) begin
            n_fail++; $display("FAIL host_write_access: got %b %h %h expected 1010 3 12345678",
                               {host_gnt, cpu_gnt, mem_wen, mem_ren}, mem_addr, mem_wdata);
        end
        host_req = 1'b0;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'd3;
        tick();
        n_checks++;
        if ({host_rsp_valid, host_rsp_err, host_rdata, cpu_gnt} !== {2'b10, 32'd0, 1'b0}) begin
            n_fail++; $display("FAIL host_write_rsp: got %b %h expected 10 0", {host_rsp_valid, host_rsp_err}, host_rdata);
        end
        tick();
        n_checks++;
        if ({cpu_gnt, mem_ren, mem_addr} !== {2'b11, 32'd3}) begin
            n_fail++; $display("FAIL cpu_read_back_gnt: got %b %h expected 11 3", {cpu_gnt, mem_ren}, mem_addr);
        end
        cpu_req = 1'b0;
        tick();
        n_checks++;
        if ({cpu_rsp_valid, cpu_rdata} !== {1'b1, 32'h12345678}) begin
            n_fail++; $display("FAIL cpu_read_back_data: got %b %h expected 1 12345678", cpu_rsp_valid, cpu_rdata);
        end
        tick();
    endtask

    task automatic test_fairness();
        logic [1:0] exp_g, exp_r;
        do_reset();
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'd1;
        host_req = 1'b1; host_we = 1'b0; host_addr = 32'd2;
        for (int i = 0; i < 12; i++) begin
            tick();
            exp_g = (i % 2 == 0) ? (((i / 2) % 2 == 0) ? 2'b10 : 2'b01) : 2'b00;
            exp_r = (i % 2 == 1) ? (((i / 2) % 2 == 0) ? 2'b10 : 2'b01) : 2'b00;
            n_checks++;
            if ({cpu_gnt, host_gnt} !== exp_g) begin
                n_fail++; $display("FAIL fair_gnt[%0d]: got %b expected %b", i, {cpu_gnt, host_gnt}, exp_g);
            end
            n_checks++;
            if ({cpu_rsp_valid, host_rsp_valid} !== exp_r) begin
                n_fail++; $display("FAIL fair_rsp[%0d]: got %b expected %b", i, {cpu_rsp_valid, host_rsp_valid}, exp_r);
            end
        end
        cpu_req = 1'b0; host_req = 1'b0;
        tick();
        tick();
    endtask

    task automatic test_range();
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h83;
        tick();
        n_checks++;
        if ({cpu_gnt, mem_wen, mem_ren} !== 3'b100) begin
            n_fail++; $display("FAIL range_top_access: got %b expected 100", {cpu_gnt, mem_wen, mem_ren});
        end
        cpu_req = 1'b0;
        tick();
        n_checks++;
        if ({cpu_rsp_valid, cpu_rsp_err, cpu_rdata} !== {2'b11, 32'd0}) begin
            n_fail++; $display("FAIL range_top_rsp: got %b %h expected 11 0", {cpu_rsp_valid, cpu_rsp_err}, cpu_rdata);
        end
        cpu_req = 1'b1; cpu_addr = 32'h82;
        tick();
        n_checks++;
        if ({cpu_gnt, mem_ren, mem_addr} !== {2'b11, 32'h82}) begin
            n_fail++; $display("FAIL range_last_access: got %b %h expected 11 82", {cpu_gnt, mem_ren}, mem_addr);
        end
        cpu_req = 1'b0;
        tick();
        n_checks++;
        if ({cpu_rsp_valid, cpu_rsp_err, cpu_rdata} !== {2'b10, 32'hA5A50082}) begin
            n_fail++; $display("FAIL range_last_rsp: got %b %h expected 10 a5a50082", {cpu_rsp_valid, cpu_rsp_err}, cpu_rdata);
        end
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h1000_0002; cpu_wdata = 32'hFFFF0000;
        tick();
        n_checks++;
        if ({cpu_gnt, mem_wen, mem_ren} !== 3'b100) begin
            n_fail++; $display("FAIL range_upper_access: got %b expected 100", {cpu_gnt, mem_wen, mem_ren});
        end
        cpu_req = 1'b0;
        tick();
        n_checks++;
        if ({cpu_rsp_valid, cpu_rsp_err, cpu_rdata} !== {2'b11, 32'd0}) begin
            n_fail++; $display("FAIL range_upper_rsp: got %b %h expected 11 0", {cpu_rsp_valid, cpu_rsp_err}, cpu_rdata);
        end
        tick();
    endtask

    task automatic test_reset_mid_access();
        host_req = 1'b1; host_we = 1'b0; host_addr = 32'd5;
        tick();
        n_checks++;
        if ({host_gnt, mem_ren} !== 2'b11) begin
            n_fail++; $display("FAIL rst_mid_pre: got %b expected 11", {host_gnt, mem_ren});
        end
        rst_n = 1'b0;
        host_req = 1'b0;
        #1;
        n_checks++;
        if (all_out !== '0) begin n_fail++; $display("FAIL rst_mid_outputs: got %h expected 0", all_out); end
        tick();
        rst_n = 1'b1;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'd5;
        host_req = 1'b1; host_we = 1'b0; host_addr = 32'd6;
        tick();
        n_checks++;
        if ({cpu_gnt, host_gnt} !== 2'b10) begin
            n_fail++; $display("FAIL rst_tie_gnt: got %b expected 10", {cpu_gnt, host_gnt});
        end
        cpu_req = 1'b0;
        tick();
        n_checks++;
        if ({cpu_rsp_valid, cpu_rsp_err, cpu_rdata} !== {2'b10, 32'hDEADBEEF}) begin
            n_fail++; $display("FAIL rst_cpu_rsp: got %b %h expected 10 deadbeef", {cpu_rsp_valid, cpu_rsp_err}, cpu_rdata);
        end
        tick();
        n_checks++;
        if ({cpu_gnt, host_gnt} !== 2'b01) begin
            n_fail++; $display("FAIL rst_host_gnt: got %b expected 01", {cpu_gnt, host_gnt});
        end
        host_req = 1'b0;
        tick();
        n_checks++;
        if ({host_rsp_valid, host_rdata} !== {1'b1, 32'hCAFE0006}) begin
            n_fail++; $display("FAIL rst_host_rsp: got %b %h expected 1 cafe0006", host_rsp_valid, host_rdata);
        end
        tick();
    endtask

    task automatic test_req_dropped();
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'd7;
        tick();
        cpu_req = 1'b0;
        host_req = 1'b1; host_we = 1'b1; host_addr = 32'd9; host_wdata = 32'h0BAD0BAD;
        tick();
        host_req = 1'b0;
        tick();
        n_checks++;
        if ({host_gnt, cpu_gnt, mem_wen, mem_ren} !== 4'b0000) begin
            n_fail++; $display("FAIL drop_no_gnt: got %b expected 0000", {host_gnt, cpu_gnt, mem_wen, mem_ren});
        end
        tick();
        n_checks++;
        if ({host_gnt, host_rsp_valid, mem_wen, mem_ren} !== 4'b0000) begin
            n_fail++; $display("FAIL drop_no_rsp: got %b expected 0000", {host_gnt, host_rsp_valid, mem_wen, mem_ren});
        end
    endtask

    // Transaction-level model: an accept may happen two edges after the previous one,
    // ties go to whoever was not served last, reads see all earlier writes.
    task automatic test_random();
        logic        pend [2];
        logic        p_we [2];
        logic [31:0] p_addr [2];
        logic [31:0] p_wdata [2];
        logic        cur_v [2], cur_e [2], stg_v [2], stg_e [2];
        logic [31:0] cur_d [2], stg_d [2];
        logic [1:0]  exp_gnt, exp_men;
        logic        acc, e;
        int          last_acc, cyc, w, rr;
        do_reset();
        for (int i = 0; i < int'(MSIZE); i++) ref_mem[i] = mem[i];
        for (int r = 0; r < 2; r++) begin
            pend[r] = 1'b0; p_we[r] = 1'b0; p_addr[r] = '0; p_wdata[r] = '0;
            cur_v[r] = 1'b0; cur_e[r] = 1'b0; cur_d[r] = '0;
        end
        last_acc = -100; cyc = 0; rr = 1; w = 0;
        for (int n = 0; n < 400; n++) begin
            for (int r = 0; r < 2; r++) begin
                if (!pend[r] && $urandom_range(0, 2) != 0) begin
                    pend[r]    = 1'b1;
                    p_we[r]    = 1'($urandom_range(0, 1));
                    p_addr[r]  = ($urandom_range(0, 15) == 0) ? $urandom : 32'($urandom_range(0, 140));
                    p_wdata[r] = $urandom;
                end
            end
            cpu_req  = pend[0]; cpu_we  = p_we[0]; cpu_addr  = p_addr[0]; cpu_wdata  = p_wdata[0];
            host_req = pend[1]; host_we = p_we[1]; host_addr = p_addr[1]; host_wdata = p_wdata[1];
            for (int r = 0; r < 2; r++) begin stg_v[r] = 1'b0; stg_e[r] = 1'b0; stg_d[r] = '0; end
            exp_gnt = 2'b00; exp_men = 2'b00;
            acc = (cyc + 1 - last_acc >= 2) && (pend[0] || pend[1]);
            if (acc) begin
                w = (pend[0] && pend[1]) ? ((rr == 1) ? 0 : 1) : (pend[0] ? 0 : 1);
                rr = w; last_acc = cyc + 1;
                e = (p_addr[w] >= MSIZE);
                stg_v[w] = 1'b1; stg_e[w] = e;
                if (!e && !p_we[w]) stg_d[w] = ref_mem[p_addr[w]];
                if (!e && p_we[w]) ref_mem[p_addr[w]] = p_wdata[w];
                exp_gnt = (w == 0) ? 2'b10 : 2'b01;
                exp_men = e ? 2'b00 : (p_we[w] ? 2'b10 : 2'b01);
            end
            tick();
            cyc++;
            n_checks++;
            if ({cpu_gnt, host_gnt} !== exp_gnt) begin
                n_fail++; $display("FAIL rnd_gnt @%0d: got %b expected %b", cyc, {cpu_gnt, host_gnt}, exp_gnt);
            end
            n_checks++;
            if ({mem_wen, mem_ren} !== exp_men) begin
                n_fail++; $display("FAIL rnd_mem_en @%0d: got %b expected %b", cyc, {mem_wen, mem_ren}, exp_men);
            end
            n_checks++;
            if ({cpu_rsp_valid, cpu_rsp_err, cpu_rdata} !== {cur_v[0], cur_e[0], cur_d[0]}) begin
                n_fail++; $display("FAIL rnd_cpu_rsp @%0d: got %b%b %h expected %b%b %h", cyc,
                                   cpu_rsp_valid, cpu_rsp_err, cpu_rdata, cur_v[0], cur_e[0], cur_d[0]);
            end
            n_checks++;
            if ({host_rsp_valid, host_rsp_err, host_rdata} !== {cur_v[1], cur_e[1], cur_d[1]}) begin
                n_fail++; $display("FAIL rnd_host_rsp @%0d: got %b%b %h expected %b%b %h", cyc,
                                   host_rsp_valid, host_rsp_err, host_rdata, cur_v[1], cur_e[1], cur_d[1]);
            end
            for (int r = 0; r < 2; r++) begin cur_v[r] = stg_v[r]; cur_e[r] = stg_e[r]; cur_d[r] = stg_d[r]; end
            if (acc) pend[w] = 1'b0;
        end
        cpu_req = 1'b0; host_req = 1'b0;
        tick();
        tick();
    endtask

    initial begin
        for (int i = 0; i < int'(MSIZE); i++) mem[i] = $urandom;
        mem[5]   = 32'hDEADBEEF;
        mem[6]   = 32'hCAFE0006;
        mem[130] = 32'hA5A50082;
        test_reset();
        test_cpu_read();
        test_host_write_cpu_read();
        test_fairness();
        test_range();
        test_reset_mid_access();
        test_req_dropped();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
